// File: rtl/cmac_tx_gate.sv
// Packet-safe gate between the user TX AXI-stream and the CMAC axis_tx port.
// Forwards traffic only after alignment has been stable for a holdoff period and never cuts a packet short.
module cmac_tx_gate #(
  parameter int DATA_WIDTH     = 512,
  parameter int SYNC_FF        = 4,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                    tx_clk,
  input  logic                    tx_reset,
  input  logic                    tx_aligned,
  input  logic                    drop_when_down,
  input  logic [DATA_WIDTH-1:0]   axis_in_tdata,
  input  logic [DATA_WIDTH/8-1:0] axis_in_tkeep,
  input  logic                    axis_in_tlast,
  input  logic                    axis_in_tvalid,
  output logic                    axis_in_tready,
  output logic [DATA_WIDTH-1:0]   axis_out_tdata,
  output logic [DATA_WIDTH/8-1:0] axis_out_tkeep,
  output logic                    axis_out_tlast,
  output logic                    axis_out_tvalid,
  input  logic                    axis_out_tready,
  output logic                    link_up,
  output logic [CNT_WIDTH-1:0]    dropped_packets,
  output logic [CNT_WIDTH-1:0]    link_up_events
);

  localparam int TIMER_WIDTH = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_DOWN,
    ST_HOLDOFF,
    ST_UP,
    ST_FLUSH
  } state_t;

  state_t                 state_reg, state_next;
  logic [TIMER_WIDTH-1:0] timer_reg, timer_next;
  logic [SYNC_FF-1:0]     sync_reg;
  logic                   sync_aligned;
  logic                   in_packet_reg, in_packet_next;
  logic                   accepted;
  logic                   drop_event;
  logic                   up_event;
  logic [CNT_WIDTH-1:0]   dropped_reg, link_up_events_reg;

  assign sync_aligned   = sync_reg[SYNC_FF-1];
  assign axis_out_tdata = axis_in_tdata;
  assign axis_out_tkeep = axis_in_tkeep;
  assign axis_out_tlast = axis_in_tlast;

  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_FF-2:0], tx_aligned};
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    up_event        = 1'b0;
    axis_in_tready  = 1'b0;
    axis_out_tvalid = 1'b0;
    link_up         = 1'b0;

    case (state_reg)
      ST_DOWN, ST_HOLDOFF: axis_in_tready = drop_when_down;
      ST_UP: begin
        axis_in_tready  = axis_out_tready;
        axis_out_tvalid = axis_in_tvalid;
        link_up         = 1'b1;
      end
      ST_FLUSH: begin
        axis_in_tready  = axis_out_tready;
        axis_out_tvalid = axis_in_tvalid;
      end
      default: ;
    endcase

    // Handshake is frozen while reset is held, whatever state we are in.
    if (tx_reset) begin
      axis_in_tready  = 1'b0;
      axis_out_tvalid = 1'b0;
    end

    accepted       = axis_in_tvalid & axis_in_tready;
    in_packet_next = accepted ? ~axis_in_tlast : in_packet_reg;

    case (state_reg)
      ST_DOWN: begin
        if (sync_aligned && !in_packet_reg) begin
          state_next = ST_HOLDOFF;
          timer_next = TIMER_LOAD;
        end
      end
      ST_HOLDOFF: begin
        if (!sync_aligned) begin
          state_next = ST_DOWN;
        end else if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else if (!in_packet_reg) begin
          state_next = ST_UP;
          up_event   = 1'b1;
        end
      end
      ST_UP: begin
        // Losing alignment mid-packet must still let the tail out, or the CMAC underflows.
        if (!sync_aligned) begin
          state_next = in_packet_next ? ST_FLUSH : ST_DOWN;
        end
      end
      ST_FLUSH: begin
        if (accepted && axis_in_tlast) begin
          state_next = ST_DOWN;
        end
      end
      default: state_next = ST_DOWN;
    endcase
  end

  assign drop_event = accepted & axis_in_tlast &
                      ((state_reg == ST_DOWN) | (state_reg == ST_HOLDOFF));

  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      state_reg          <= ST_DOWN;
      timer_reg          <= '0;
      in_packet_reg      <= 1'b0;
      dropped_reg        <= '0;
      link_up_events_reg <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      in_packet_reg <= in_packet_next;
      if (drop_event && dropped_reg != CNT_MAX) begin
        dropped_reg <= dropped_reg + 1'b1;
      end
      if (up_event && link_up_events_reg != CNT_MAX) begin
        link_up_events_reg <= link_up_events_reg + 1'b1;
      end
    end
  end

  assign dropped_packets = dropped_reg;
  assign link_up_events  = link_up_events_reg;

endmodule

// File: tb/tb_cmac_tx_gate.sv
// Directed-sequence bench for cmac_tx_gate with random payloads; a beat scoreboard and
// arithmetic expectations for timing and counters form the reference.
module tb_cmac_tx_gate;

  localparam int DW      = 64;
  localparam int KW      = DW / 8;
  localparam int SYNC_FF = 4;
  localparam int HOLD    = 16;
  localparam int CW      = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          tx_clk = 1'b0;
  logic          tx_reset;
  logic          tx_aligned;
  logic          drop_when_down;
  logic [DW-1:0] axis_in_tdata;
  logic [KW-1:0] axis_in_tkeep;
  logic          axis_in_tlast;
  logic          axis_in_tvalid;
  logic          axis_in_tready;
  logic [DW-1:0] axis_out_tdata;
  logic [KW-1:0] axis_out_tkeep;
  logic          axis_out_tlast;
  logic          axis_out_tvalid;
  logic          axis_out_tready;
  logic          link_up;
  logic [CW-1:0] dropped_packets;
  logic [CW-1:0] link_up_events;

  always #5 tx_clk = ~tx_clk;

  cmac_tx_gate #(
    .DATA_WIDTH(DW),
    .SYNC_FF(SYNC_FF),
    .HOLDOFF_CYCLES(HOLD),
    .CNT_WIDTH(CW)
  ) dut (
    .tx_clk(tx_clk),
    .tx_reset(tx_reset),
    .tx_aligned(tx_aligned),
    .drop_when_down(drop_when_down),
    .axis_in_tdata(axis_in_tdata),
    .axis_in_tkeep(axis_in_tkeep),
    .axis_in_tlast(axis_in_tlast),
    .axis_in_tvalid(axis_in_tvalid),
    .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata),
    .axis_out_tkeep(axis_out_tkeep),
    .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tready(axis_out_tready),
    .link_up(link_up),
    .dropped_packets(dropped_packets),
    .link_up_events(link_up_events)
  );

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t out_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc_n    = 0;
  int    drop_cyc = -1;
  int    fall_cyc = -1;
  int    exp_drops = 0;
  int    exp_ups   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    cyc_n++;
    #1;
  endtask

  // mode 0: pass-through expected; 1: discard expected; 2: backpressure until link_up, then pass-through.
  // At local cycle evt_cyc the task drives tx_aligned to evt_val (evt_cyc < 0 disables it).
  task automatic send_pkt(input int nbeats, input int mode, input bit toggle,
                          input int evt_cyc, input bit evt_val, input bit expect_fwd);
    int    local_c;
    bit    acc;
    beat_t b;
    local_c = 0;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.last = (i == nbeats - 1);
      if (expect_fwd) exp_q.push_back(b);
      axis_in_tdata  = b.data;
      axis_in_tkeep  = b.keep;
      axis_in_tlast  = b.last;
      axis_in_tvalid = 1'b1;
      acc = 1'b0;
      while (!acc) begin
        if (local_c == evt_cyc) begin
          tx_aligned = evt_val;
          drop_cyc   = cyc_n;
        end
        if (toggle) axis_out_tready = ~axis_out_tready;
        #1;
        chk("pass_tdata", axis_out_tdata, b.data);
        chk("pass_tkeep", axis_out_tkeep, b.keep);
        chk("pass_tlast", axis_out_tlast, b.last);
        if (mode == 0 || (mode == 2 && link_up === 1'b1)) begin
          chk("fwd_tvalid", axis_out_tvalid, 1'b1);
          chk("fwd_tready", axis_in_tready, axis_out_tready);
        end else if (mode == 1) begin
          chk("drop_tready", axis_in_tready, 1'b1);
          chk("drop_tvalid", axis_out_tvalid, 1'b0);
        end else begin
          chk("bp_tready", axis_in_tready, 1'b0);
          chk("bp_tvalid", axis_out_tvalid, 1'b0);
        end
        if (evt_cyc >= 0 && !evt_val && local_c >= evt_cyc && fall_cyc < 0 && link_up === 1'b0)
          fall_cyc = cyc_n;
        if (axis_out_tvalid === 1'b1 && axis_out_tready === 1'b1)
          out_q.push_back({axis_out_tlast, axis_out_tkeep, axis_out_tdata});
        acc = (axis_in_tvalid === 1'b1 && axis_in_tready === 1'b1);
        tick();
        local_c++;
        if (!acc && local_c > 200) begin
          chk("pkt_timeout", 1'b1, 1'b0);
          axis_in_tvalid = 1'b0;
          return;
        end
      end
    end
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
  endtask

  initial begin
    int  rise;
    bit  seen_up;
    int  ncmp;

    // Reset with aligned already high and a valid beat waiting.
    tx_reset        = 1'b1;
    tx_aligned      = 1'b1;
    drop_when_down  = 1'b1;
    axis_in_tdata   = '0;
    axis_in_tkeep   = '0;
    axis_in_tlast   = 1'b0;
    axis_in_tvalid  = 1'b1;
    axis_out_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_tready", axis_in_tready, 1'b0);
      chk("rst_tvalid", axis_out_tvalid, 1'b0);
      chk("rst_link_up", link_up, 1'b0);
      chk("rst_dropped", dropped_packets, '0);
      chk("rst_ups", link_up_events, '0);
    end
    tx_reset       = 1'b0;
    axis_in_tvalid = 1'b0;
    rise = -1;
    for (int k = 1; k <= 40 && rise < 0; k++) begin
      tick();
      if (link_up === 1'b1) rise = k;
    end
    chk("linkup_edge", rise, SYNC_FF + 1 + HOLD);
    exp_ups = 1;
    chk("ups_after_first", link_up_events, exp_ups);

    // Pass-through with a toggling downstream ready.
    send_pkt(4, 0, 1'b1, -1, 1'b0, 1'b1);
    axis_out_tready = 1'b1;
    chk("dropped_after_pass", dropped_packets, exp_drops);

    // Alignment lost during beat 2 of an 8-beat packet: tail is still forwarded.
    fall_cyc = -1;
    send_pkt(8, 0, 1'b0, 1, 1'b0, 1'b1);
    chk("fall_seen", (fall_cyc >= 0), 1'b1);
    chk("fall_within5", (fall_cyc - drop_cyc >= 1) && (fall_cyc - drop_cyc <= 5), 1'b1);
    send_pkt(3, 1, 1'b0, -1, 1'b0, 1'b0);
    exp_drops = 1;
    chk("dropped_one", dropped_packets, exp_drops);
    chk("down_link_up", link_up, 1'b0);

    // Backpressure while down, then forwarding once the link comes back.
    drop_when_down = 1'b0;
    send_pkt(2, 2, 1'b0, 5, 1'b1, 1'b1);
    exp_ups = 2;
    chk("ups_after_bp", link_up_events, exp_ups);
    chk("bp_link_up", link_up, 1'b1);
    chk("dropped_after_bp", dropped_packets, exp_drops);

    // Short alignment glitch must not bring the link up.
    tx_aligned = 1'b0;
    for (int i = 0; i < 20 && link_up !== 1'b0; i++) tick();
    chk("glitch_pre_down", link_up, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    tx_aligned = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    tx_aligned = 1'b0;
    seen_up = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (link_up === 1'b1) seen_up = 1'b1;
    end
    chk("glitch_no_up", seen_up, 1'b0);
    chk("glitch_ups", link_up_events, exp_ups);

    // Drop-counter saturation.
    drop_when_down = 1'b1;
    for (int p = 0; p < 20; p++) begin
      send_pkt($urandom_range(1, 3), 1, 1'b0, -1, 1'b0, 1'b0);
      exp_drops = (exp_drops + 1 > CNT_SAT) ? CNT_SAT : exp_drops + 1;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    chk("dropped_sat", dropped_packets, exp_drops);
    send_pkt(2, 1, 1'b0, -1, 1'b0, 1'b0);
    chk("dropped_hold", dropped_packets, CNT_SAT);

    // Every forwarded beat must match the scoreboard, in order.
    chk("beat_count", out_q.size(), exp_q.size());
    ncmp = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < ncmp; i++) chk("beat", out_q[i], exp_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cmac_tx_gate.md
Name: cmac_tx_gate

Overview:
- Packet-safe gate between the user TX AXI-stream and the CMAC axis_tx port. It is the transmit-side counterpart of the RX alignment controller.
- Forwards traffic only after PCS alignment has been stable for a holdoff period.
- Never truncates a packet already started, because a mid-packet tvalid gap causes a CMAC TX underflow.
- While the link is down, it either discards whole packets (counting them) or applies backpressure.

Parameters:
- DATA_WIDTH, 512, AXIS data width in bits; KEEP width is DATA_WIDTH/8.
- SYNC_FF, 4, synchronizer depth for tx_aligned; minimum 2.
- HOLDOFF_CYCLES, 1024, cycles alignment must be stable before forwarding; minimum 1.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- tx_clk  in  1  CMAC TX user clock; everything is synchronous to it.
- tx_reset  in  1  synchronous, active-high reset.
- tx_aligned  in  1  stat_rx_aligned from the CMAC; asynchronous, synchronized internally.
- drop_when_down  in  1  1 = discard packets while down; 0 = backpressure while down. Quasi-static.
- axis_in_tdata  in  DATA_WIDTH  user TX data.
- axis_in_tkeep  in  DATA_WIDTH/8  user TX keep.
- axis_in_tlast  in  1  user TX last.
- axis_in_tvalid  in  1  user TX valid.
- axis_in_tready  out  1  user TX ready.
- axis_out_tdata  out  DATA_WIDTH  to CMAC.
- axis_out_tkeep  out  DATA_WIDTH/8  to CMAC.
- axis_out_tlast  out  1  to CMAC.
- axis_out_tvalid  out  1  to CMAC.
- axis_out_tready  in  1  from CMAC.
- link_up  out  1  high only in state UP.
- dropped_packets  out  CNT_WIDTH  count of discarded packets; saturating.
- link_up_events  out  CNT_WIDTH  count of entries into UP; saturating.

Behaviour:
- Synchronizer: SYNC_FF flops, all reset to 0, producing sync_aligned.
- in_packet register:
  - Set on an accepted input beat (axis_in_tvalid & axis_in_tready) with tlast=0.
  - Cleared on an accepted beat with tlast=1.
  - in_packet_next is the value in_packet will take after the current edge.
- Datapath is always combinational: tdata, tkeep and tlast pass straight through with zero latency.
- FSM (registered state, reset to DOWN):
  - DOWN:
    - Output side: axis_out_tvalid=0; axis_in_tready=drop_when_down; link_up=0.
    - Each accepted tlast beat increments dropped_packets.
    - Go to HOLDOFF when sync_aligned=1 and in_packet=0. Load timer = HOLDOFF_CYCLES-1 on that transition.
  - HOLDOFF:
    - Output side: same as DOWN; dropping continues.
    - sync_aligned=0 → DOWN immediately.
    - timer≠0 → decrement.
    - timer=0 and in_packet=0 → UP, and increment link_up_events.
    - timer=0 and in_packet=1 → wait in HOLDOFF.
  - UP:
    - Output side: axis_out_tvalid=axis_in_tvalid; axis_in_tready=axis_out_tready; link_up=1.
    - sync_aligned=0 and in_packet_next=0 → DOWN.
    - sync_aligned=0 and in_packet_next=1 → FLUSH.
  - FLUSH:
    - Output side: pass-through as in UP, but link_up=0.
    - On an accepted tlast beat → DOWN, regardless of sync_aligned.
- Counters saturate at all-ones and never wrap.
- Reset:
  - tx_reset=1 forces, at that edge: state DOWN, in_packet 0, timer 0, both counters 0, synchronizer 0.
  - While tx_reset=1, axis_in_tready=0 and axis_out_tvalid=0, whatever the state.
  - A reset mid-packet abandons that packet; CMAC recovery is the system reset's concern.
- drop_when_down changing mid-packet takes effect on the next cycle. This is not required to be well-defined and is not verified.
- Timing: with aligned steady at 1 across reset release, link_up rises after rising edge SYNC_FF+1+HOLDOFF_CYCLES following the first edge with tx_reset=0.

Test Plan:
All scenarios use SYNC_FF=4, HOLDOFF_CYCLES=16, CNT_WIDTH=4.
1. Reset then link-up: tx_reset high 5 cycles with tx_aligned=1 → all outputs 0 and tready=0 during reset; link_up rises after edge 21 following release; link_up_events=1.
2. Pass-through: in UP, send a 4-beat packet while toggling axis_out_tready every cycle → output beats identical to input with zero latency; tvalid mirrors input; dropped_packets=0.
3. Loss mid-packet: drop tx_aligned during beat 2 of an 8-beat packet → link_up falls within 5 cycles; beats 3-8 still forwarded; FSM passes through FLUSH to DOWN after tlast. Next 3-beat packet with drop_when_down=1 → tready=1, tvalid_out=0, dropped_packets=1.
4. Backpressure: DOWN with drop_when_down=0 → tready=0 and no output beats. Raise tx_aligned → the packet is forwarded once link_up=1.
5. Glitch: 8-cycle tx_aligned pulse → HOLDOFF entered then aborted; link_up never asserts; link_up_events unchanged.
6. Saturation: drop 20 packets while down → dropped_packets reads 15 and holds.
